// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one-cycle-latency memory reads, buffers
// {instr,pc} in a 2-entry FIFO, and handles redirect, halt and flush.
//
// state  | meaning
// FETCH  | issuing requests while buffer space allows
// HALTED | halt opcode accepted downstream; idle until redirect or reset
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h00000000,
  parameter logic [3:0]  HALT_OPCODE = 4'b1111
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [3:0]  out_opcode,
  output logic [31:0] out_pc
);

  typedef enum logic {FETCH, HALTED} stateT;

  stateT       state, nextState;
  logic [31:0] pc;
  logic [31:0] fifoInstr [2];
  logic [31:0] fifoPc [2];
  logic        rdPtr, wrPtr;
  logic [1:0]  count;
  logic        inflight;
  logic [31:0] inflightPc;
  logic        drop;

  logic        outValid, pop, haltPop, flush, issue, push;
  logic [2:0]  occupancy;

  assign outValid  = (count != 2'd0);
  assign pop       = outValid & out_ready;
  assign haltPop   = pop && (fifoInstr[rdPtr][31:28] == HALT_OPCODE);
  assign flush     = redirect | haltPop;
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  // rst_n gate keeps the request low while reset is held
  assign issue     = rst_n && (state == FETCH) && !redirect && (occupancy < 3'd2);
  assign push      = inflight && !drop && !flush;

  assign imem_req   = issue;
  assign imem_addr  = pc;
  assign out_valid  = outValid;
  assign out_instr  = fifoInstr[rdPtr];
  assign out_opcode = fifoInstr[rdPtr][31:28];
  assign out_pc     = fifoPc[rdPtr];

  always_comb begin
    nextState = state;
    if (redirect)     nextState = FETCH;
    else if (haltPop) nextState = HALTED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inflight   <= 1'b0;
      inflightPc <= 32'h0;
      drop       <= 1'b0;
    end else begin
      state    <= nextState;
      inflight <= issue;
      drop     <= flush;
      if (issue) inflightPc <= pc;
      if (redirect)   pc <= redirect_pc;
      else if (issue) pc <= pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifoInstr[i] <= 32'h0;
        fifoPc[i]    <= 32'h0;
      end
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        fifoInstr[wrPtr] <= imem_rdata;
        fifoPc[wrPtr]    <= inflightPc;
        wrPtr            <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The issue rule bounds count + inflight at 2, so this should never fire
  fifoNoOverflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == 2'd2)));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector bench for instr_fetch: table of per-cycle stimulus and
// expected outputs, plus hand sequences for async reset and PC wrap.
module tb_instr_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [3:0]  out_opcode;
  logic [31:0] out_pc;

  logic        wReq;
  logic [31:0] wAddr;
  logic [31:0] wRdata = 32'h0;
  logic        wRedirect = 1'b0;
  logic [31:0] wRedirectPc = 32'h0;
  logic        wValid;
  logic        wReady = 1'b1;
  logic [31:0] wInstr;
  logic [3:0]  wOpcode;
  logic [31:0] wPc;

  bit haltMem = 1'b0;
  int errors = 0;
  int checks = 0;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_opcode(out_opcode), .out_pc(out_pc)
  );

  instr_fetch #(.RESET_PC(32'hFFFFFFF8)) dutWrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(wReq), .imem_addr(wAddr), .imem_rdata(wRdata),
    .redirect(wRedirect), .redirect_pc(wRedirectPc),
    .out_valid(wValid), .out_ready(wReady),
    .out_instr(wInstr), .out_opcode(wOpcode), .out_pc(wPc)
  );

  function automatic logic [31:0] memWord(input logic [31:0] addr, input bit hm);
    logic [31:0] i;
    i = addr >> 2;
    if (hm && addr == 32'h8) return {4'hF, 28'd2};
    return {4'(i % 7), 28'(i)};
  endfunction

  always @(posedge clk) imem_rdata <= imem_req ? memWord(imem_addr, haltMem) : 32'hDEADBEEF;
  always @(posedge clk) wRdata <= wReq ? memWord(wAddr, 1'b0) : 32'hDEADBEEF;

  typedef struct {
    bit          rst;
    bit          haltMem;
    bit          ready;
    bit          redir;
    logic [31:0] redirPc;
    bit          expReq;
    logic [31:0] expAddr;
    bit          expValid;
    logic [31:0] expPc;
    logic [3:0]  expOp;
  } vecT;

  vecT vecs[$];

  task automatic add(input bit rst, input bit hm, input bit rdy, input bit rd,
                     input logic [31:0] rpc, input bit er, input logic [31:0] ea,
                     input bit ev, input logic [31:0] ep, input logic [3:0] eo);
    vecT v;
    v = '{rst, hm, rdy, rd, rpc, er, ea, ev, ep, eo};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] got[$];
    logic [31:0] wrapExp [4];
    vecT v;
    wrapExp = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};

    // steady stream, one instruction per cycle
    add(1,0,1,0,0, 1,32'h00, 0,0,0);
    add(0,0,1,0,0, 1,32'h04, 0,0,0);
    add(0,0,1,0,0, 1,32'h08, 1,32'h00,0);
    add(0,0,1,0,0, 1,32'h0C, 1,32'h04,1);
    add(0,0,1,0,0, 1,32'h10, 1,32'h08,2);
    add(0,0,1,0,0, 1,32'h14, 1,32'h0C,3);
    add(0,0,1,0,0, 1,32'h18, 1,32'h10,4);
    add(0,0,1,0,0, 1,32'h1C, 1,32'h14,5);
    add(0,0,1,0,0, 1,32'h20, 1,32'h18,6);
    add(0,0,1,0,0, 1,32'h24, 1,32'h1C,0);
    // backpressure for 5 cycles
    add(1,0,1,0,0, 1,32'h00, 0,0,0);
    add(0,0,1,0,0, 1,32'h04, 0,0,0);
    for (int i = 0; i < 5; i++) add(0,0,0,0,0, 0,0, 1,32'h00,0);
    add(0,0,1,0,0, 1,32'h08, 1,32'h00,0);
    add(0,0,1,0,0, 1,32'h0C, 1,32'h04,1);
    add(0,0,1,0,0, 1,32'h10, 1,32'h08,2);
    add(0,0,1,0,0, 1,32'h14, 1,32'h0C,3);
    // redirect with in-flight response and simultaneous pop
    add(1,0,1,0,0, 1,32'h00, 0,0,0);
    add(0,0,1,0,0, 1,32'h04, 0,0,0);
    add(0,0,1,0,0, 1,32'h08, 1,32'h00,0);
    add(0,0,1,1,32'h100, 0,0, 1,32'h04,1);
    add(0,0,1,0,0, 1,32'h100, 0,0,0);
    add(0,0,1,0,0, 1,32'h104, 0,0,0);
    add(0,0,1,0,0, 1,32'h108, 1,32'h100,1);
    add(0,0,1,0,0, 1,32'h10C, 1,32'h104,2);
    // halt at addr 8, then redirect to 0x40
    add(1,1,1,0,0, 1,32'h00, 0,0,0);
    add(0,1,1,0,0, 1,32'h04, 0,0,0);
    add(0,1,1,0,0, 1,32'h08, 1,32'h00,0);
    add(0,1,1,0,0, 1,32'h0C, 1,32'h04,1);
    add(0,1,1,0,0, 1,32'h10, 1,32'h08,4'hF);
    for (int i = 0; i < 3; i++) add(0,1,1,0,0, 0,0, 0,0,0);
    add(0,1,1,1,32'h40, 0,0, 0,0,0);
    add(0,1,1,0,0, 1,32'h40, 0,0,0);
    add(0,1,1,0,0, 1,32'h44, 0,0,0);
    add(0,1,1,0,0, 1,32'h48, 1,32'h40,2);
    add(0,1,1,0,0, 1,32'h4C, 1,32'h44,3);
    // redirect in the same cycle as the halt pop
    add(1,1,1,0,0, 1,32'h00, 0,0,0);
    add(0,1,1,0,0, 1,32'h04, 0,0,0);
    add(0,1,1,0,0, 1,32'h08, 1,32'h00,0);
    add(0,1,1,0,0, 1,32'h0C, 1,32'h04,1);
    add(0,1,1,1,32'h200, 0,0, 1,32'h08,4'hF);
    add(0,1,1,0,0, 1,32'h200, 0,0,0);
    add(0,1,1,0,0, 1,32'h204, 0,0,0);
    add(0,1,1,0,0, 1,32'h208, 1,32'h200,2);

    foreach (vecs[n]) begin
      v = vecs[n];
      @(negedge clk);
      if (v.rst) begin
        rst_n = 1'b0;
        redirect = 1'b0;
        haltMem = v.haltMem;
        #1;
        check($sformatf("v%0d rstReq", n), {31'b0, imem_req}, 32'd0);
        check($sformatf("v%0d rstValid", n), {31'b0, out_valid}, 32'd0);
        check($sformatf("v%0d rstInstr", n), out_instr, 32'h0);
        check($sformatf("v%0d rstPc", n), out_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
      out_ready   = v.ready;
      redirect    = v.redir;
      redirect_pc = v.redirPc;
      #1;
      check($sformatf("v%0d req", n), {31'b0, imem_req}, {31'b0, v.expReq});
      if (v.expReq) check($sformatf("v%0d addr", n), imem_addr, v.expAddr);
      check($sformatf("v%0d valid", n), {31'b0, out_valid}, {31'b0, v.expValid});
      if (v.expValid) begin
        check($sformatf("v%0d pc", n), out_pc, v.expPc);
        check($sformatf("v%0d opcode", n), {28'b0, out_opcode}, {28'b0, v.expOp});
        check($sformatf("v%0d instr", n), out_instr, memWord(v.expPc, haltMem));
      end
    end

    // asynchronous reset in the middle of a stream
    @(negedge clk);
    redirect = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    haltMem = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("midValidBefore", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("asyncValid", {31'b0, out_valid}, 32'd0);
    check("asyncInstr", out_instr, 32'h0);
    check("asyncPc", out_pc, 32'h0);
    check("asyncReq", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("restartReq", {31'b0, imem_req}, 32'd1);
    check("restartAddr", imem_addr, 32'h0);
    @(negedge clk);
    #1;
    check("restartValidC1", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    check("restartValidC2", {31'b0, out_valid}, 32'd1);
    check("restartPc", out_pc, 32'h0);
    check("restartInstr", out_instr, memWord(32'h0, 1'b0));

    // PC wrap on the second instance
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12 && got.size() < 4; c++) begin
      #1;
      if (wValid) got.push_back(wPc);
      @(negedge clk);
    end
    check("wrapCount", got.size(), 32'd4);
    foreach (got[i]) check($sformatf("wrapPc%0d", i), got[i], wrapExp[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
